vga_cursor_ctrl: RTL and testbench

Converts four push-button directions plus a home button into the marked-block coordinates consumed by the checkerboard pixel generator (`iMarkedBlockPosX/Y`). Buttons are synchronised, debounced, edge-detected and optionally auto-repeated. Moves update an internal position that wraps at the grid edges. That position is copied to the outputs only at the start of vertical sync, so a frame never shows a half-moved marker.

---
 rtl/vga_cursor_ctrl_pkg.sv | 47 ++++
 rtl/vga_cursor_ctrl_debounce.sv | 58 +++++
 rtl/vga_cursor_ctrl.sv | 139 +++++++++++++
 tb/tb_vga_cursor_ctrl.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/vga_cursor_ctrl_pkg.sv
// Shared definitions for the cursor controller: button vector bit indices,
// default timing constants and the wrapping step helper used by the move logic.
package vga_cursor_ctrl_pkg;

   localparam int DIR_UP    = 0;
   localparam int DIR_DOWN  = 1;
   localparam int DIR_LEFT  = 2;
   localparam int DIR_RIGHT = 3;
   localparam int DIR_HOME  = 4;
   localparam int NUM_BTNS  = 5;
   localparam int NUM_DIRS  = 4;

   localparam int DEF_DEBOUNCE_CYCLES = 250000;
   localparam int DEF_REPEAT_DELAY    = 12500000;
   localparam int DEF_REPEAT_PERIOD   = 5000000;

   typedef enum logic [1:0] {
      STEP_NONE = 2'd0,
      STEP_DEC  = 2'd1,
      STEP_INC  = 2'd2
   } step_e;

   // Opposing presses on one axis cancel each other out.
   function automatic step_e stepFromPair(input logic dec, input logic inc);
      step_e step;
      step = STEP_NONE;
      if (dec && !inc) begin
         step = STEP_DEC;
      end else if (inc && !dec) begin
         step = STEP_INC;
      end
      return step;
   endfunction

   function automatic logic [3:0] stepPos(input logic [3:0] pos, input step_e step,
                                          input logic [3:0] maxPos);
      logic [3:0] next;
      next = pos;
      case (step)
         STEP_DEC: next = (pos == 4'd0) ? maxPos : pos - 4'd1;
         STEP_INC: next = (pos == maxPos) ? 4'd0 : pos + 4'd1;
         default:  next = pos;
      endcase
      return next;
   endfunction

endpackage

// File: rtl/vga_cursor_ctrl_debounce.sv
// One push-button front end: two-flop synchroniser, counting debouncer and a
// registered one-cycle pulse on each accepted rising level.
module button_debounce
   import vga_cursor_ctrl_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
   input  logic Clock,
   input  logic Reset,
   input  logic iRaw,
   output logic oLevel,
   output logic oRise
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_DONE = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync1_q, sync2_q;
   logic          level_q, level_d;
   logic          rise_q, rise_d;
   logic [CW-1:0] cnt_q, cnt_d;

   // The count only runs while the synced input disagrees with the accepted
   // level; it flips the level on reaching the limit, so it never wraps.
   always_comb begin
      level_d = level_q;
      rise_d  = 1'b0;
      cnt_d   = '0;
      if (sync2_q != level_q) begin
         if (cnt_q == CNT_DONE) begin
            level_d = sync2_q;
            rise_d  = sync2_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         level_q <= 1'b0;
         rise_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= iRaw;
         sync2_q <= sync1_q;
         level_q <= level_d;
         rise_q  <= rise_d;
         cnt_q   <= cnt_d;
      end
   end

   assign oLevel = level_q;
   assign oRise  = rise_q;

endmodule

// File: rtl/vga_cursor_ctrl.sv
// Marked-block cursor for the checkerboard generator: debounced buttons with
// auto-repeat move a wrapping grid position that is shown at each vsync start.
module vga_cursor_ctrl
   import vga_cursor_ctrl_pkg::*;
#(
   parameter int BLOCKS_X        = 4,
   parameter int BLOCKS_Y        = 4,
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
   parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
   input  logic       Clock,
   input  logic       Reset,
   input  logic       iBtnUp,
   input  logic       iBtnDown,
   input  logic       iBtnLeft,
   input  logic       iBtnRight,
   input  logic       iBtnHome,
   input  logic       iVGAVerticalSync,
   output logic [3:0] oMarkedBlockPosX,
   output logic [3:0] oMarkedBlockPosY,
   output logic       oMoveFlag
);

   localparam logic [3:0]  MAX_X      = 4'(BLOCKS_X - 1);
   localparam logic [3:0]  MAX_Y      = 4'(BLOCKS_Y - 1);
   localparam logic [31:0] RPT_DELAY  = 32'(REPEAT_DELAY);
   localparam logic [31:0] RPT_PERIOD = 32'(REPEAT_PERIOD);
   localparam logic        RPT_EN     = (REPEAT_DELAY != 0);

   logic [NUM_BTNS-1:0] rawBtn, btnLevel, btnRise;
   logic [NUM_DIRS-1:0] held, dirEvent;
   logic                homeEvent, rptTick;

   logic [NUM_DIRS-1:0] heldPrev_q, heldPrev_d;
   logic [31:0]         rptCnt_q, rptCnt_d;
   logic                repeating_q, repeating_d;
   logic [3:0]          posX_q, posX_d, posY_q, posY_d;
   logic                moveFlag_q, moveFlag_d;
   logic                vsPrev_q;
   logic [3:0]          outX_q, outX_d, outY_q, outY_d;

   assign rawBtn[DIR_UP]    = iBtnUp;
   assign rawBtn[DIR_DOWN]  = iBtnDown;
   assign rawBtn[DIR_LEFT]  = iBtnLeft;
   assign rawBtn[DIR_RIGHT] = iBtnRight;
   assign rawBtn[DIR_HOME]  = iBtnHome;

   for (genvar g = 0; g < NUM_BTNS; g++) begin : gBtn
      button_debounce #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) uDebounce (
         .Clock (Clock),
         .Reset (Reset),
         .iRaw  (rawBtn[g]),
         .oLevel(btnLevel[g]),
         .oRise (btnRise[g])
      );
   end

   assign held = btnLevel[NUM_DIRS-1:0];

   // Counter holds the cycles since the held set last changed (or since the
   // last tick); the press cycle counts as 1 so ticks land exactly on the delay.
   always_comb begin
      heldPrev_d  = held;
      rptCnt_d    = rptCnt_q;
      repeating_d = repeating_q;
      rptTick     = 1'b0;
      if (held != heldPrev_q) begin
         rptCnt_d    = 32'd1;
         repeating_d = 1'b0;
      end else if (held == '0) begin
         rptCnt_d    = '0;
         repeating_d = 1'b0;
      end else if (RPT_EN && (rptCnt_q == (repeating_q ? RPT_PERIOD : RPT_DELAY))) begin
         rptTick     = 1'b1;
         rptCnt_d    = 32'd1;
         repeating_d = 1'b1;
      end else if (rptCnt_q != '1) begin
         rptCnt_d = rptCnt_q + 32'd1;
      end
   end

   assign dirEvent  = btnRise[NUM_DIRS-1:0] | ({NUM_DIRS{rptTick}} & held);
   assign homeEvent = btnRise[DIR_HOME];

   // Home wins over any direction; a single-block axis maps every step to 0.
   always_comb begin
      posX_d = posX_q;
      posY_d = posY_q;
      if (homeEvent) begin
         posX_d = 4'd0;
         posY_d = 4'd0;
      end else begin
         posX_d = stepPos(posX_q, stepFromPair(dirEvent[DIR_LEFT], dirEvent[DIR_RIGHT]), MAX_X);
         posY_d = stepPos(posY_q, stepFromPair(dirEvent[DIR_UP], dirEvent[DIR_DOWN]), MAX_Y);
      end
      moveFlag_d = (posX_d != posX_q) || (posY_d != posY_q);
   end

   always_comb begin
      outX_d = outX_q;
      outY_d = outY_q;
      if (vsPrev_q && !iVGAVerticalSync) begin
         outX_d = posX_q;
         outY_d = posY_q;
      end
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         heldPrev_q  <= '0;
         rptCnt_q    <= '0;
         repeating_q <= 1'b0;
         posX_q      <= 4'd0;
         posY_q      <= 4'd0;
         moveFlag_q  <= 1'b0;
         vsPrev_q    <= 1'b0;
         outX_q      <= 4'd0;
         outY_q      <= 4'd0;
      end else begin
         heldPrev_q  <= heldPrev_d;
         rptCnt_q    <= rptCnt_d;
         repeating_q <= repeating_d;
         posX_q      <= posX_d;
         posY_q      <= posY_d;
         moveFlag_q  <= moveFlag_d;
         vsPrev_q    <= iVGAVerticalSync;
         outX_q      <= outX_d;
         outY_q      <= outY_d;
      end
   end

   assign oMarkedBlockPosX = outX_q;
   assign oMarkedBlockPosY = outY_q;
   assign oMoveFlag        = moveFlag_q;

endmodule

// File: tb/tb_vga_cursor_ctrl.sv
// Directed bench for vga_cursor_ctrl with short debounce/repeat timing; expected
// positions and pulse timing are hand-computed from the button sequences below.
module tb_vga_cursor_ctrl;
   import vga_cursor_ctrl_pkg::*;

   localparam logic [4:0] B_UP    = 5'b00001;
   localparam logic [4:0] B_DOWN  = 5'b00010;
   localparam logic [4:0] B_LEFT  = 5'b00100;
   localparam logic [4:0] B_RIGHT = 5'b01000;
   localparam logic [4:0] B_HOME  = 5'b10000;

   logic       Clock = 1'b0;
   logic       Reset;
   logic       iBtnUp, iBtnDown, iBtnLeft, iBtnRight, iBtnHome;
   logic       iVGAVerticalSync;
   logic [3:0] oMarkedBlockPosX, oMarkedBlockPosY;
   logic       oMoveFlag;

   int checkCount = 0;
   int errorCount = 0;
   int flagCount  = 0;
   int cycleCnt   = 0;
   int flagTimes[$];
   int flagBase;
   int expGaps[6] = '{0, 20, 28, 36, 44, 52};

   vga_cursor_ctrl #(
      .BLOCKS_X(4),
      .BLOCKS_Y(4),
      .DEBOUNCE_CYCLES(4),
      .REPEAT_DELAY(20),
      .REPEAT_PERIOD(8)
   ) dut (
      .Clock           (Clock),
      .Reset           (Reset),
      .iBtnUp          (iBtnUp),
      .iBtnDown        (iBtnDown),
      .iBtnLeft        (iBtnLeft),
      .iBtnRight       (iBtnRight),
      .iBtnHome        (iBtnHome),
      .iVGAVerticalSync(iVGAVerticalSync),
      .oMarkedBlockPosX(oMarkedBlockPosX),
      .oMarkedBlockPosY(oMarkedBlockPosY),
      .oMoveFlag       (oMoveFlag)
   );

   always #5 Clock = ~Clock;

   always @(posedge Clock) cycleCnt <= cycleCnt + 1;

   // Every move pulse is logged with its cycle so gaps between moves can be checked.
   always @(negedge Clock) begin
      if (oMoveFlag) begin
         flagCount = flagCount + 1;
         flagTimes.push_back(cycleCnt);
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checkCount = checkCount + 1;
      if (observed !== expected) begin
         errorCount = errorCount + 1;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
      end
   endtask

   task automatic waitCycles(input int n);
      repeat (n) @(posedge Clock);
      #1;
   endtask

   task automatic setButtons(input logic [4:0] mask);
      iBtnUp    = mask[DIR_UP];
      iBtnDown  = mask[DIR_DOWN];
      iBtnLeft  = mask[DIR_LEFT];
      iBtnRight = mask[DIR_RIGHT];
      iBtnHome  = mask[DIR_HOME];
   endtask

   // Hold a button set for some cycles, then release and let the debouncers settle.
   task automatic applyStimulus(input logic [4:0] mask, input int holdCycles);
      setButtons(mask);
      waitCycles(holdCycles);
      setButtons(5'b0);
      waitCycles(14);
   endtask

   task automatic checkDisplay(input string tag, input int expX, input int expY);
      iVGAVerticalSync = 1'b0;
      waitCycles(1);
      iVGAVerticalSync = 1'b1;
      waitCycles(1);
      checkOutput({tag, "_x"}, 32'(oMarkedBlockPosX), 32'(expX));
      checkOutput({tag, "_y"}, 32'(oMarkedBlockPosY), 32'(expY));
   endtask

   initial begin
      Reset            = 1'b1;
      iVGAVerticalSync = 1'b1;
      setButtons(5'b0);
      waitCycles(3);
      checkOutput("resetX", 32'(oMarkedBlockPosX), 32'd0);
      checkOutput("resetY", 32'(oMarkedBlockPosY), 32'd0);
      checkOutput("resetFlag", 32'(oMoveFlag), 32'd0);
      Reset = 1'b0;
      waitCycles(2);
      for (int i = 0; i < 3; i++) checkDisplay($sformatf("idle%0d", i), 0, 0);
      checkOutput("idleFlags", 32'(flagCount), 32'd0);

      applyStimulus(B_RIGHT, 3);
      checkOutput("glitchFlags", 32'(flagCount), 32'd0);

      setButtons(B_RIGHT);
      for (int i = 1; i <= 8; i++) begin
         waitCycles(1);
         if (i >= 6) checkOutput($sformatf("rightLat%0d", i), 32'(oMoveFlag), 32'(i == 7));
      end
      checkOutput("noShowBeforeVsync", 32'(oMarkedBlockPosX), 32'd0);
      waitCycles(2);
      setButtons(5'b0);
      waitCycles(14);
      checkOutput("rightFlags", 32'(flagCount), 32'd1);
      checkDisplay("right1", 1, 0);

      applyStimulus(B_HOME, 6);
      checkDisplay("home", 0, 0);
      applyStimulus(B_LEFT, 6);
      checkDisplay("leftWrap", 3, 0);
      applyStimulus(B_UP, 6);
      checkDisplay("upWrap", 3, 3);
      applyStimulus(B_DOWN, 6);
      checkDisplay("downWrap", 3, 0);

      flagBase = flagCount;
      applyStimulus(B_UP | B_DOWN, 6);
      checkOutput("upDownFlags", 32'(flagCount - flagBase), 32'd0);
      checkDisplay("upDown", 3, 0);

      applyStimulus(B_HOME, 6);
      applyStimulus(B_RIGHT, 6);
      applyStimulus(B_DOWN, 6);
      checkDisplay("frameMoves", 1, 1);
      flagBase = flagCount;
      applyStimulus(B_UP | B_RIGHT, 6);
      checkOutput("diagFlags", 32'(flagCount - flagBase), 32'd1);
      checkDisplay("diag", 2, 0);

      applyStimulus(B_HOME, 6);
      flagTimes.delete();
      applyStimulus(B_RIGHT, 60);
      checkOutput("rptCount", 32'(flagTimes.size()), 32'd6);
      if (flagTimes.size() == 6) begin
         for (int k = 1; k < 6; k++)
            checkOutput($sformatf("rptGap%0d", k), 32'(flagTimes[k] - flagTimes[0]), 32'(expGaps[k]));
      end
      checkDisplay("rptFinal", 2, 0);

      applyStimulus(B_LEFT, 6);
      applyStimulus(B_UP, 6);
      checkDisplay("preHome", 1, 3);
      flagTimes.delete();
      setButtons(B_RIGHT);
      waitCycles(4);
      setButtons(B_RIGHT | B_HOME);
      waitCycles(4);
      setButtons(B_HOME);
      waitCycles(6);
      setButtons(5'b0);
      waitCycles(14);
      checkOutput("homeRptCount", 32'(flagTimes.size()), 32'd2);
      if (flagTimes.size() == 2)
         checkOutput("homeRptGap", 32'(flagTimes[1] - flagTimes[0]), 32'd4);
      checkDisplay("homeRpt", 0, 0);

      applyStimulus(B_RIGHT, 6);
      checkDisplay("preReset", 1, 0);
      setButtons(B_DOWN);
      waitCycles(4);
      Reset = 1'b1;
      waitCycles(1);
      checkOutput("midResetX", 32'(oMarkedBlockPosX), 32'd0);
      checkOutput("midResetFlag", 32'(oMoveFlag), 32'd0);
      Reset = 1'b0;
      for (int i = 1; i <= 7; i++) begin
         waitCycles(1);
         checkOutput($sformatf("reDebounce%0d", i), 32'(oMoveFlag), 32'(i == 7));
      end
      setButtons(5'b0);
      waitCycles(14);
      checkDisplay("afterReset", 0, 1);

      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule
